// File: rtl/edge_hist_pkg.sv
// rtl/edge_hist_pkg.sv - shared types, widths and bin increment helper (EDGE_HIST_SATURATE_EN selects saturation)
package edge_hist_pkg;

   localparam int         HIST_CNT_W  = 32;
   localparam int         FRAME_CNT_W = 16;
   localparam logic [3:0] MEM_BE_ALL  = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT,
      RD,
      WR,
      DONE
   } hist_state_t;

   function automatic logic [HIST_CNT_W-1:0] hist_inc(input logic [HIST_CNT_W-1:0] v);
`ifdef EDGE_HIST_SATURATE_EN
      return (v == {HIST_CNT_W{1'b1}}) ? v : v + HIST_CNT_W'(1);
`else
      return v + HIST_CNT_W'(1);
`endif
   endfunction

endpackage

// File: rtl/edge_hist_accumulator_if.sv
// rtl/edge_hist_accumulator_if.sv - bin-index stream sink and histogram memory master bundle
interface edge_hist_accumulator_if #(
   parameter int ADDR_W = 12
);
   import edge_hist_pkg::*;

   logic [ADDR_W-1:0]     in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_startofpacket;
   logic                  in_endofpacket;

   logic [ADDR_W-1:0]     mem_address;
   logic                  mem_chipselect;
   logic                  mem_write;
   logic [3:0]            mem_byteenable;
   logic [HIST_CNT_W-1:0] mem_writedata;
   logic                  mem_clken;
   logic [HIST_CNT_W-1:0] mem_readdata;

   // master: the accumulator; slave: bin source plus memory
   modport master (
      input  in_data, in_valid, in_startofpacket, in_endofpacket, mem_readdata,
      output in_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
             mem_writedata, mem_clken
   );

   modport slave (
      output in_data, in_valid, in_startofpacket, in_endofpacket, mem_readdata,
      input  in_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
             mem_writedata, mem_clken
   );

endinterface

// File: rtl/edge_hist_accumulator.sv
// rtl/edge_hist_accumulator.sv - per-frame column histogram via clear pass then read-modify-write per bin
// EDGE_HIST_SATURATE_EN: bin counts saturate instead of wrapping (see edge_hist_pkg::hist_inc).
module edge_hist_accumulator
   import edge_hist_pkg::*;
#(
   parameter int NUM_BINS = 4096,
   parameter int ADDR_W   = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   edge_hist_accumulator_if.master bus,
   output logic                   busy,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_BINS - 1);

   hist_state_t            state_q, state_d;
   logic [ADDR_W-1:0]      hold_bin_q, hold_bin_d;
   logic                   hold_eop_q, hold_eop_d;
   logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
   logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

   logic                   in_ready_q, in_ready_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic [ADDR_W-1:0]      mem_address_q, mem_address_d;
   logic                   mem_cs_q, mem_cs_d;
   logic                   mem_write_q, mem_write_d;
   logic                   wr_phase_q, wr_phase_d;

   logic                   accept;
   logic                   in_range;

   always_comb begin
      state_d       = state_q;
      hold_bin_d    = hold_bin_q;
      hold_eop_d    = hold_eop_q;
      clr_cnt_d     = clr_cnt_q;
      frame_count_d = frame_count_q;
      accept        = bus.in_valid && (state_q == IDLE || state_q == WAIT);

      case (state_q)
         IDLE: begin
            if (accept && bus.in_startofpacket) begin
               hold_bin_d = bus.in_data;
               hold_eop_d = bus.in_endofpacket;
               clr_cnt_d  = '0;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d = RD;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         WAIT: begin
            if (accept) begin
               hold_bin_d = bus.in_data;
               hold_eop_d = bus.in_endofpacket;
               // a fresh SOP abandons the partial frame and restarts the clear pass
               if (bus.in_startofpacket) begin
                  clr_cnt_d = '0;
                  state_d   = CLEAR;
               end else begin
                  state_d   = RD;
               end
            end
         end
         RD:      state_d = WR;
         WR:      state_d = hold_eop_q ? DONE : WAIT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d == DONE) begin
         frame_count_d = frame_count_q + FRAME_CNT_W'(1);
      end
   end

   // Outputs are registered from the next state so the bus lines up with the state itself.
   always_comb begin
      in_range      = 32'(hold_bin_d) < 32'(NUM_BINS);
      in_ready_d    = (state_d == IDLE) || (state_d == WAIT);
      busy_d        = (state_d != IDLE);
      frame_done_d  = (state_d == DONE);
      mem_address_d = '0;
      mem_cs_d      = 1'b0;
      mem_write_d   = 1'b0;
      wr_phase_d    = 1'b0;

      case (state_d)
         CLEAR: begin
            mem_cs_d      = 1'b1;
            mem_write_d   = 1'b1;
            mem_address_d = clr_cnt_d;
         end
         RD: begin
            mem_cs_d      = in_range;
            mem_address_d = hold_bin_d;
         end
         WR: begin
            mem_cs_d      = in_range;
            mem_write_d   = in_range;
            mem_address_d = hold_bin_d;
            wr_phase_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         hold_bin_q    <= '0;
         hold_eop_q    <= 1'b0;
         clr_cnt_q     <= '0;
         frame_count_q <= '0;
         in_ready_q    <= 1'b1;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         mem_address_q <= '0;
         mem_cs_q      <= 1'b0;
         mem_write_q   <= 1'b0;
         wr_phase_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_bin_q    <= hold_bin_d;
         hold_eop_q    <= hold_eop_d;
         clr_cnt_q     <= clr_cnt_d;
         frame_count_q <= frame_count_d;
         in_ready_q    <= in_ready_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         mem_address_q <= mem_address_d;
         mem_cs_q      <= mem_cs_d;
         mem_write_q   <= mem_write_d;
         wr_phase_q    <= wr_phase_d;
      end
   end

   // Read data arrives in WR, so the incremented value is formed in that same cycle.
   assign bus.mem_writedata  = wr_phase_q ? hist_inc(bus.mem_readdata) : '0;
   assign bus.in_ready       = in_ready_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_chipselect = mem_cs_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_byteenable = MEM_BE_ALL;
   assign bus.mem_clken      = 1'b1;
   assign busy               = busy_q;
   assign frame_done         = frame_done_q;
   assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_edge_hist_accumulator.sv
// tb/tb_edge_hist_accumulator.sv - directed self-checking bench with a 1-cycle-latency memory model
module tb_edge_hist_accumulator;

   localparam int NB = 16;
   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;

   int n_pass = 0;
   int n_total = 0;

   edge_hist_accumulator_if #(.ADDR_W(AW)) ifc ();

   edge_hist_accumulator #(.NUM_BINS(NB), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (ifc.master),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   logic [31:0]   mem [0:255];
   logic [31:0]   rd_q;
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [31:0]   pre_data = '0;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (ifc.mem_chipselect && ifc.mem_clken) begin
         if (ifc.mem_write) mem[ifc.mem_address] <= ifc.mem_writedata;
         else               rd_q <= mem[ifc.mem_address];
      end
   end
   assign ifc.mem_readdata = rd_q;

   int fd_cnt = 0;
   int cs_cnt = 0;
   int rd_cnt = 0;
   int busy_cnt = 0;
   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (ifc.mem_chipselect) cs_cnt++;
      if (ifc.mem_chipselect && !ifc.mem_write) rd_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 32; i++) preload(AW'(i), 32'hA5A5_0000 | 32'(i));
   endtask

   task automatic send_beat(input logic [AW-1:0] bin, input logic sop, input logic eop);
      bit got = 1'b0;
      ifc.in_data          = bin;
      ifc.in_startofpacket = sop;
      ifc.in_endofpacket   = eop;
      ifc.in_valid         = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (ifc.in_ready) got = 1'b1;
      end
      if (got) @(posedge clk);
      #1;
      ifc.in_valid         = 1'b0;
      ifc.in_startofpacket = 1'b0;
      ifc.in_endofpacket   = 1'b0;
      n_total++;
      if (!got) $display("FAIL accept bin=%0d: in_ready=0, expected 1 within 300 cycles", bin);
      else n_pass++;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (frame_done) seen = 1'b1;
      end
      n_total++;
      if (!seen) $display("FAIL frame_done_wait: frame_done=0, expected 1 within 300 cycles");
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ifc.in_valid = 1'b0;
      ifc.in_data = '0;
      ifc.in_startofpacket = 1'b0;
      ifc.in_endofpacket = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total += 11;
      if (ifc.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", ifc.in_ready); else n_pass++;
      if (ifc.mem_chipselect !== 1'b0) $display("FAIL rst_cs: got %b expected 0", ifc.mem_chipselect); else n_pass++;
      if (ifc.mem_write !== 1'b0) $display("FAIL rst_write: got %b expected 0", ifc.mem_write); else n_pass++;
      if (ifc.mem_address !== 8'd0) $display("FAIL rst_addr: got %0d expected 0", ifc.mem_address); else n_pass++;
      if (ifc.mem_writedata !== 32'd0) $display("FAIL rst_wdata: got %h expected 0", ifc.mem_writedata); else n_pass++;
      if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", frame_done); else n_pass++;
      if (frame_count !== 16'd0) $display("FAIL rst_frame_count: got %0d expected 0", frame_count); else n_pass++;
      if (ifc.mem_byteenable !== 4'hF) $display("FAIL rst_be: got %h expected f", ifc.mem_byteenable); else n_pass++;
      if (ifc.mem_clken !== 1'b1) $display("FAIL rst_clken: got %b expected 1", ifc.mem_clken); else n_pass++;
      reset = 1'b0;
      @(posedge clk);
      #1;
      if (ifc.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", ifc.in_ready); else n_pass++;
   endtask

   task automatic test_idle_discard();
      int cs0 = cs_cnt;
      int b0  = busy_cnt;
      send_beat(8'd4, 1'b0, 1'b0);
      send_beat(8'd6, 1'b0, 1'b1);
      send_beat(8'd1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_total += 2;
      if (cs_cnt - cs0 !== 0) $display("FAIL idle_cs: got %0d chipselect cycles expected 0", cs_cnt - cs0); else n_pass++;
      if (busy_cnt - b0 !== 0) $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_cnt - b0); else n_pass++;
   endtask

   task automatic test_basic_frame();
      int fd0, cs0, rd0;
      logic [31:0] exp;
      fill_mem();
      fd0 = fd_cnt; cs0 = cs_cnt; rd0 = rd_cnt;
      send_beat(8'd5, 1'b1, 1'b0);
      send_beat(8'd5, 1'b0, 1'b0);
      send_beat(8'd5, 1'b0, 1'b0);
      send_beat(8'd7, 1'b0, 1'b1);
      wait_done();
      for (int i = 0; i < NB; i++) begin
         exp = (i == 5) ? 32'd3 : (i == 7) ? 32'd1 : 32'd0;
         n_total++;
         if (mem[i] !== exp) $display("FAIL basic_bin%0d: got %0d expected %0d", i, mem[i], exp); else n_pass++;
      end
      n_total += 4;
      if (fd_cnt - fd0 !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", fd_cnt - fd0); else n_pass++;
      if (frame_count !== 16'd1) $display("FAIL basic_frame_count: got %0d expected 1", frame_count); else n_pass++;
      if (cs_cnt - cs0 !== 24) $display("FAIL basic_cs_cycles: got %0d expected 24", cs_cnt - cs0); else n_pass++;
      if (rd_cnt - rd0 !== 4) $display("FAIL basic_reads: got %0d expected 4", rd_cnt - rd0); else n_pass++;
   endtask

   task automatic test_abort();
      int fd0 = fd_cnt;
      send_beat(8'd3, 1'b1, 1'b0);
      send_beat(8'd9, 1'b1, 1'b0);
      send_beat(8'd9, 1'b0, 1'b1);
      wait_done();
      n_total += 4;
      if (mem[3] !== 32'd0) $display("FAIL abort_bin3: got %0d expected 0", mem[3]); else n_pass++;
      if (mem[9] !== 32'd2) $display("FAIL abort_bin9: got %0d expected 2", mem[9]); else n_pass++;
      if (fd_cnt - fd0 !== 1) $display("FAIL abort_done_pulses: got %0d expected 1", fd_cnt - fd0); else n_pass++;
      if (frame_count !== 16'd2) $display("FAIL abort_frame_count: got %0d expected 2", frame_count); else n_pass++;
   endtask

   task automatic test_out_of_range();
      int cs0, rd0;
      preload(8'd20, 32'h0000_1234);
      cs0 = cs_cnt; rd0 = rd_cnt;
      send_beat(8'd20, 1'b1, 1'b1);
      wait_done();
      n_total += 4;
      if (cs_cnt - cs0 !== NB) $display("FAIL oor_cs_cycles: got %0d expected %0d", cs_cnt - cs0, NB); else n_pass++;
      if (rd_cnt - rd0 !== 0) $display("FAIL oor_reads: got %0d expected 0", rd_cnt - rd0); else n_pass++;
      if (mem[20] !== 32'h0000_1234) $display("FAIL oor_mem20: got %h expected 00001234", mem[20]); else n_pass++;
      if (frame_count !== 16'd3) $display("FAIL oor_frame_count: got %0d expected 3", frame_count); else n_pass++;
   endtask

   task automatic test_wrap_or_saturate();
      logic [31:0] exp;
      bit in_wait = 1'b0;
`ifdef EDGE_HIST_SATURATE_EN
      exp = 32'hFFFF_FFFF;
`else
      exp = 32'h0000_0000;
`endif
      send_beat(8'd20, 1'b1, 1'b0);
      for (int i = 0; i < 300 && !in_wait; i++) begin
         @(negedge clk);
         if (ifc.in_ready) in_wait = 1'b1;
      end
      @(posedge clk);
      #1;
      preload(8'd2, 32'hFFFF_FFFF);
      send_beat(8'd2, 1'b0, 1'b1);
      wait_done();
      n_total += 2;
      if (mem[2] !== exp) $display("FAIL incr_limit_bin2: got %h expected %h", mem[2], exp); else n_pass++;
      if (frame_count !== 16'd4) $display("FAIL incr_frame_count: got %0d expected 4", frame_count); else n_pass++;
   endtask

   task automatic test_reset_mid_clear();
      int fd0 = fd_cnt;
      send_beat(8'd1, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (busy !== 1'b1) $display("FAIL midclr_busy_before: got %b expected 1", busy); else n_pass++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_total += 4;
      if (ifc.in_ready !== 1'b1) $display("FAIL midclr_in_ready: got %b expected 1", ifc.in_ready); else n_pass++;
      if (busy !== 1'b0) $display("FAIL midclr_busy: got %b expected 0", busy); else n_pass++;
      if (ifc.mem_chipselect !== 1'b0) $display("FAIL midclr_cs: got %b expected 0", ifc.mem_chipselect); else n_pass++;
      if (frame_count !== 16'd0) $display("FAIL midclr_frame_count: got %0d expected 0", frame_count); else n_pass++;
      repeat (40) @(posedge clk);
      #1;
      n_total += 2;
      if (fd_cnt - fd0 !== 0) $display("FAIL midclr_done_pulses: got %0d expected 0", fd_cnt - fd0); else n_pass++;
      if (busy !== 1'b0) $display("FAIL midclr_busy_late: got %b expected 0", busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_idle_discard();
      test_basic_frame();
      test_abort();
      test_out_of_range();
      test_wrap_or_saturate();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
